// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flip-flop, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         co
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t         state;
  logic [N-1:0]   sa;
  logic [N-1:0]   sb;
  logic [N-1:0]   res;
  logic           carry;
  logic [CW-1:0]  cnt;

  logic           sum_bit;
  logic           carry_next;
  logic [N-1:0]   res_next;

  // Full-adder cell on the operand LSBs; the sum bit enters the result at the MSB.
  always_comb begin
    sum_bit    = sa[0] ^ sb[0] ^ carry;
    carry_next = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    res_next   = (res >> 1) | (N'(sum_bit) << (N - 1));
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= ci;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          res   <= res_next;
          carry <= carry_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            // Last bit: publish the complete result together with the final carry.
            s     <= res_next;
            co    <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= carry ^ carry_next;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (N=8): latency, hold, ignored start, reset abort.
// Define SERIAL_ADDER_OVF_EN for both files to also check the ovf output.
module tb_serial_adder;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         co;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
  logic         last_ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [N-1:0] last_s;
  logic         last_co;

  serial_adder #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start in the current cycle (cycle 0); a second start pulse with junk operands is
  // raised in cycle glitch (0 = none). Ends in cycle N+2 with the block idle.
  task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vci,
                        input logic [N-1:0] exp_s, input logic exp_co, input logic exp_ovf,
                        input int glitch);
    start = 1'b1;
    a     = va;
    b     = vb;
    ci    = vci;
    tick();
    for (int i = 1; i <= N; i++) begin
      start = (i == glitch);
      a     = 8'hFF;
      b     = 8'hFF;
      ci    = 1'b1;
      check($sformatf("busy_c%0d", i), busy, 1'b1);
      check($sformatf("done_c%0d", i), done, 1'b0);
      check($sformatf("s_hold_c%0d", i), s, last_s);
      check($sformatf("co_hold_c%0d", i), co, last_co);
      tick();
    end
    start = 1'b0;
    check("done_pulse", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("sum", s, exp_s);
    check("carry_out", co, exp_co);
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf", ovf, exp_ovf);
    last_ovf = exp_ovf;
`endif
    last_s  = exp_s;
    last_co = exp_co;
    tick();
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h33;
    b     = 8'h44;
    ci    = 1'b1;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_s", s, 8'h00);
    check("rst_co", co, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 1'b0);
    last_ovf = 1'b0;
`endif
    last_s  = 8'h00;
    last_co = 1'b0;
    rst     = 1'b0;
    start   = 1'b0;
    tick();

    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    // Back-to-back: second start in the cycle after done.
    run_op(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0);
    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);

    // Start pulse mid-RUN must be ignored and not queued.
    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 4);
    tick();
    check("no_queued_start", busy, 1'b0);
    tick();
    check("no_queued_done", done, 1'b0);

    // Reset in cycle 5 of a RUN aborts with no done pulse.
    start = 1'b1;
    a     = 8'h3C;
    b     = 8'h0F;
    ci    = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("abort_done_c%0d", i), done, 1'b0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_s", s, 8'h00);
    check("abort_co", co, 1'b0);
    last_s  = 8'h00;
    last_co = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    check("abort_ovf", ovf, 1'b0);
    last_ovf = 1'b0;
`endif
    // Fresh start in the first cycle after reset deasserts.
    run_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 0);
    run_op(8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
